// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load-store controller in front of the byte-addressed data_mem.
// Accepts one load/store at a time (valid/ready), checks funct3 legality,
// alignment and range, drives the memory port for exactly one ACCESS cycle
// and returns a registered response (extended load data or a fault code).
//
// Ports:
//   lsu_clk, lsu_rst           clock, asynchronous active-high reset
//   lsu_req_*                  request channel (valid/ready, load, funct3,
//                              base, offset, wdata, rd)
//   lsu_rsp_*                  response channel (valid/ready, rdata, rd, fault)
//   data_m_addr/in/R/W/instr   memory command port
//   data_m_out                 combinational load data from the memory
module lsu_ctrl #(
    parameter int unsigned DEPTH = 180
) (
    input  logic        lsu_clk,
    input  logic        lsu_rst,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_req_load,
    input  logic [2:0]  lsu_req_funct3,
    input  logic [31:0] lsu_req_base,
    input  logic [31:0] lsu_req_offset,
    input  logic [31:0] lsu_req_wdata,
    input  logic [4:0]  lsu_req_rd,
    output logic        lsu_rsp_valid,
    input  logic        lsu_rsp_ready,
    output logic [31:0] lsu_rsp_rdata,
    output logic [4:0]  lsu_rsp_rd,
    output logic [1:0]  lsu_rsp_fault,
    output logic [31:0] data_m_addr,
    output logic [31:0] data_m_in,
    output logic        data_m_R,
    output logic        data_m_W,
    output logic [2:0]  data_m_instr,
    input  logic [31:0] data_m_out
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [1:0] FaultOk    = 2'b00;
    localparam logic [1:0] FaultAlign = 2'b01;
    localparam logic [1:0] FaultRange = 2'b10;
    localparam logic [1:0] FaultIll   = 2'b11;

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;
    logic        load_q;
    logic [2:0]  instr_q;
    logic [1:0]  fault_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic [31:0] req_addr;
    logic [2:0]  req_instr;
    logic [2:0]  req_size;
    logic        req_illegal;
    logic        req_misaligned;
    logic        req_out_of_range;
    logic [1:0]  req_fault;
    logic [31:0] load_ext;

    // Request decode: address, access code, size and fault classification.
    always_comb begin
        req_addr    = lsu_req_base + lsu_req_offset;
        req_instr   = 3'd0;
        req_size    = 3'd1;
        req_illegal = 1'b0;
        if (lsu_req_load) begin
            case (lsu_req_funct3)
                3'b000:  begin req_instr = 3'd0; req_size = 3'd1; end
                3'b001:  begin req_instr = 3'd1; req_size = 3'd2; end
                3'b010:  begin req_instr = 3'd2; req_size = 3'd4; end
                3'b100:  begin req_instr = 3'd3; req_size = 3'd1; end
                3'b101:  begin req_instr = 3'd4; req_size = 3'd2; end
                default: req_illegal = 1'b1;
            endcase
        end else begin
            case (lsu_req_funct3)
                3'b000:  begin req_instr = 3'd5; req_size = 3'd1; end
                3'b001:  begin req_instr = 3'd6; req_size = 3'd2; end
                3'b010:  begin req_instr = 3'd7; req_size = 3'd4; end
                default: req_illegal = 1'b1;
            endcase
        end

        req_misaligned = ((req_size == 3'd2) && req_addr[0]) ||
                         ((req_size == 3'd4) && (req_addr[1:0] != 2'b00));
        // 33-bit compare: addresses near 2^32 must not wrap into range.
        req_out_of_range = {1'b0, req_addr} > (33'(DEPTH) - 33'(req_size));

        if (req_illegal) begin
            req_fault = FaultIll;
        end else if (req_misaligned) begin
            req_fault = FaultAlign;
        end else if (req_out_of_range) begin
            req_fault = FaultRange;
        end else begin
            req_fault = FaultOk;
        end
    end

    // Load data extension; idempotent if the memory already extends.
    always_comb begin
        case (instr_q)
            3'd0:    load_ext = {{24{data_m_out[7]}}, data_m_out[7:0]};
            3'd1:    load_ext = {{16{data_m_out[15]}}, data_m_out[15:0]};
            3'd3:    load_ext = {24'd0, data_m_out[7:0]};
            3'd4:    load_ext = {16'd0, data_m_out[15:0]};
            default: load_ext = data_m_out;
        endcase
    end

    assign accept = lsu_req_valid && (state_q == StIdle);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (req_fault == FaultOk) ? StAccess : StResp;
                end
            end
            StAccess: state_d = StResp;
            StResp: begin
                if (lsu_rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge lsu_clk or posedge lsu_rst) begin
        if (lsu_rst) begin
            state_q <= StIdle;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rd_q    <= 5'd0;
            load_q  <= 1'b0;
            instr_q <= 3'd0;
            fault_q <= FaultOk;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= lsu_req_wdata;
                rd_q    <= lsu_req_rd;
                load_q  <= lsu_req_load;
                instr_q <= req_instr;
                fault_q <= req_fault;
                rdata_q <= 32'd0;
            end else if ((state_q == StAccess) && load_q) begin
                rdata_q <= load_ext;
            end
        end
    end

    // Strobes decode from registered state so reset kills them at once.
    assign data_m_R      = (state_q == StAccess) && load_q;
    assign data_m_W      = (state_q == StAccess) && !load_q;
    assign data_m_addr   = addr_q;
    assign data_m_in     = wdata_q;
    assign data_m_instr  = instr_q;

    assign lsu_req_ready = (state_q == StIdle);
    assign lsu_rsp_valid = (state_q == StResp);
    assign lsu_rsp_rdata = rdata_q;
    assign lsu_rsp_rd    = rd_q;
    assign lsu_rsp_fault = fault_q;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load-store controller that initiates every access to the byte-addressed `data_mem` block on behalf of the RV32I core. It accepts one load or store request at a time over a valid/ready handshake and checks alignment and range. It translates RISC-V funct3 into the memory's access code and drives the memory port for exactly one cycle. It returns a registered response carrying load data or a fault code.

## Interface
- `DEPTH`, 180: data memory size in bytes; the access range check uses it.
- `lsu_clk` in 1: clock; all state updates on the rising edge.
- `lsu_rst` in 1: asynchronous, active-high reset.
- `lsu_req_valid` in 1: request present.
- `lsu_req_ready` out 1: controller can accept a request; high only in IDLE.
- `lsu_req_load` in 1: 1 = load, 0 = store.
- `lsu_req_funct3` in 3: RISC-V funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- `lsu_req_base` in 32: rs1 value.
- `lsu_req_offset` in 32: sign-extended immediate.
- `lsu_req_wdata` in 32: store data (rs2).
- `lsu_req_rd` in 5: load destination register.
- `lsu_rsp_valid` out 1: response present.
- `lsu_rsp_ready` in 1: consumer takes the response.
- `lsu_rsp_rdata` out 32: extended load data; 0 for stores and faults.
- `lsu_rsp_rd` out 5: echoed `lsu_req_rd`.
- `lsu_rsp_fault` out 2: 00 ok, 01 misaligned, 10 out of range, 11 illegal funct3.
- `data_m_addr` out 32: memory byte address.
- `data_m_in` out 32: memory write data.
- `data_m_R` out 1: memory read enable.
- `data_m_W` out 1: memory write enable.
- `data_m_instr` out 3: memory access code (LB 0, LH 1, LW 2, LBU 3, LHU 4, SB 5, SH 6, SW 7).
- `data_m_out` in 32: combinational load data from the memory.

## Operation
- States: IDLE, ACCESS, RESP.
- **Accept.** A request is accepted on a clock edge when `lsu_req_valid && lsu_req_ready`.
  - On accept, register: address = base + offset (mod 2^32), wdata, rd, load flag, mapped access code and fault code.
- **Access size.** Byte = 1, half = 2, word = 4.
- **Fault priority:** illegal > misaligned > range.
  - Illegal: load funct3 ∈ {011, 110, 111}, or store funct3 ≥ 011.
  - Misaligned: half access with addr[0] = 1, or word access with addr[1:0] ≠ 00.
  - Range: addr > DEPTH − size. Compare unsigned at 33 bits so that addresses near 2^32 cannot wrap into the valid range.
- **Transitions.**
  - IDLE → ACCESS on accept with no fault.
  - IDLE → RESP on accept with a fault.
  - ACCESS → RESP unconditionally.
  - RESP → IDLE when `lsu_rsp_ready`.
- **ACCESS cycle.**
  - `data_m_R` = load flag and `data_m_W` = !load flag; both are decoded from the registered state.
  - For loads, `data_m_out` is captured into `lsu_rsp_rdata` at the ACCESS → RESP edge.
  - For stores, the memory writes at that same edge.
- **Faulted requests** never assert `data_m_R` or `data_m_W`. `lsu_rsp_rdata` = 0.
- **Outside ACCESS,** `data_m_R` = `data_m_W` = 0. `data_m_addr`, `data_m_in` and `data_m_instr` hold the last registered values.

## Timing
- **Reset values:**
  - State IDLE; `lsu_req_ready` = 1.
  - `lsu_rsp_valid` = 0, `lsu_rsp_rdata` = 0, `lsu_rsp_rd` = 0, `lsu_rsp_fault` = 00.
  - `data_m_addr` = 0, `data_m_in` = 0, `data_m_instr` = 0, `data_m_R` = 0, `data_m_W` = 0.
- **Latency.** Accept at edge N; ACCESS during cycle N+1; `lsu_rsp_valid` from N+2.
  - A faulted request gives `lsu_rsp_valid` from N+1.
- **Throughput.** Minimum 3 cycles per good request and 2 per faulted request; only one request is outstanding.
- **Response hold.** Response fields are stable while `lsu_rsp_valid && !lsu_rsp_ready`.
  - `lsu_req_ready` rises in the cycle after the response is taken.
- **Reset mid-operation.** Asserting `lsu_rst` in ACCESS drops `data_m_W` and `data_m_R` immediately, so no store reaches memory.
  - A pending response is discarded.
- **Request changes while not ready** are ignored.

## Test plan
- SW base 0x10, offset 4, wdata 0xDEADBEEF:
  - `data_m_W` = 1 for one cycle with addr 0x14 and instr 7.
  - Response fault 00 at N+2.
  - A following LW at 0x14 returns 0xDEADBEEF on `lsu_rsp_rdata`.
- SB 0x80 to addr 0x20, then:
  - LB → 0xFFFFFF80.
  - LBU → 0x00000080.
  - LH with base 0x20, offset −1 (addr 0x1F) → fault 01, and no `data_m_R` pulse.
- LW at addr 176 (DEPTH 180) → ok. LW at 177 → fault 01 (misaligned beats range). LW at 180 → fault 10. LB at 0xFFFFFFFF → fault 10.
- Load with funct3 011 → fault 11 at N+1, with `data_m_R` and `data_m_W` never asserted.
- Hold `lsu_rsp_ready` = 0 for 5 cycles after an LHU of 0x8001:
  - `lsu_rsp_rdata` stays 0x00008001 and `lsu_req_ready` stays 0.
  - When ready rises, IDLE is reached next cycle.
- Assert `lsu_rst` during the ACCESS cycle of SW 0x12345678 to addr 0x40:
  - `data_m_W` falls at once and all outputs take reset values.
  - A subsequent LW at 0x40 returns the prior contents.
